// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between N_REQ byte producers.
// Latches the winner's byte and parity settings, pulses DATA_VALID once, then tracks Busy.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 15,
    localparam int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_par_en_i,
    input  logic [N_REQ-1:0]            req_par_typ_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]       p_data_o,
    output logic                        par_en_o,
    output logic                        par_typ_o,
    output logic                        data_valid_o,
    input  logic                        busy_i,
    output logic                        active_o,
    output logic [ID_W-1:0]             cur_id_o,
    output logic                        timeout_err_o
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [7:0]      TIMEOUT_CNT = 8'(BUSY_TIMEOUT);
    localparam logic [ID_W-1:0] LAST_ID     = ID_W'(N_REQ - 1);

    logic [1:0]            state_q,   state_d;
    logic [ID_W-1:0]       ptr_q,     ptr_d;
    logic [ID_W-1:0]       cur_id_q,  cur_id_d;
    logic [DATA_WIDTH-1:0] p_data_q,  p_data_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [7:0]            cnt_q,     cnt_d;
    logic                  active_q,  active_d;
    logic                  timeout_err;

    logic                  found;
    logic [ID_W-1:0]       win;
    logic [ID_W-1:0]       cand_id;

    // First requesting index at or above ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        cand_id = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_id = ID_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && req_i[cand_id]) begin
                found = 1'b1;
                win   = cand_id;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        p_data_d    = p_data_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        cnt_d       = cnt_q;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found && !busy_i) begin
                    p_data_d  = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
                    par_en_d  = req_par_en_i[win];
                    par_typ_d = req_par_typ_i[win];
                    cur_id_d  = win;
                    ptr_d     = (win == LAST_ID) ? '0 : win + ID_W'(1);
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
        end
    end

    // Grant and DATA_VALID decode from the LAUNCH state so reset clears them at once.
    assign gnt_o         = (state_q == S_LAUNCH) ? (N_REQ'(1) << cur_id_q) : '0;
    assign data_valid_o  = (state_q == S_LAUNCH);
    assign timeout_err_o = timeout_err;
    assign p_data_o      = p_data_q;
    assign par_en_o      = par_en_q;
    assign par_typ_o     = par_typ_q;
    assign active_o      = active_q;
    assign cur_id_o      = cur_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; Busy is driven by the bench in place of a real transmitter.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_par_en = '0;
    logic [3:0]  req_par_typ = '0;
    logic [3:0]  gnt;
    logic [7:0]  p_data;
    logic        par_en;
    logic        par_typ;
    logic        dv;
    logic        busy = 1'b0;
    logic        active;
    logic [1:0]  cur_id;
    logic        tmo;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .N_REQ(4),
        .DATA_WIDTH(8),
        .BUSY_TIMEOUT(15)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_data_i    (req_data),
        .req_par_en_i  (req_par_en),
        .req_par_typ_i (req_par_typ),
        .gnt_o         (gnt),
        .p_data_o      (p_data),
        .par_en_o      (par_en),
        .par_typ_o     (par_typ),
        .data_valid_o  (dv),
        .busy_i        (busy),
        .active_o      (active),
        .cur_id_o      (cur_id),
        .timeout_err_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Ticks until DATA_VALID is seen; lat = ticks taken, or -1 if the bound expires.
    task automatic wait_dv(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (dv === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Called in the LAUNCH cycle: emulate a short frame and return to IDLE.
    task automatic finish_frame;
        tick();
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({gnt, dv, active, tmo, par_en, par_typ} !== 10'b0 || p_data !== 8'h00 || cur_id !== 2'd0) begin
            bad++;
            $display("FAIL reset: gnt=%b dv=%b act=%b tmo=%b pe=%b pt=%b pd=%h id=%0d, need all 0",
                     gnt, dv, active, tmo, par_en, par_typ, p_data, cur_id);
        end
        rst = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0 || dv !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: gnt=%b dv=%b act=%b, need 0", gnt, dv, active);
        end
    endtask

    task automatic test_single;
        req_data    = {8'h44, 8'h33, 8'hA5, 8'h11};
        req_par_en  = 4'b0010;
        req_par_typ = 4'b0010;
        req         = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010 || dv !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: gnt=%b dv=%b, need 0010/1", gnt, dv);
        end
        total++;
        if (p_data !== 8'hA5 || par_en !== 1'b1 || par_typ !== 1'b1 || cur_id !== 2'd1 || active !== 1'b1) begin
            bad++;
            $display("FAIL single_latch: pd=%h pe=%b pt=%b id=%0d act=%b, need a5/1/1/1/1",
                     p_data, par_en, par_typ, cur_id, active);
        end
        req = 4'b0000;
        tick();
        total++;
        if (dv !== 1'b0 || gnt !== 4'b0) begin
            bad++;
            $display("FAIL single_dv_width: dv=%b gnt=%b, need 0/0000", dv, gnt);
        end
        busy = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (active !== 1'b1 || dv !== 1'b0) begin
            bad++;
            $display("FAIL single_in_frame: act=%b dv=%b, need 1/0", active, dv);
        end
        busy = 1'b0;
        tick();
        total++;
        if (active !== 1'b0 || p_data !== 8'hA5 || cur_id !== 2'd1) begin
            bad++;
            $display("FAIL single_end: act=%b pd=%h id=%0d, need 0/a5/1", active, p_data, cur_id);
        end
    endtask

    task automatic test_round_robin;
        int lat;
        int exp_id;
        rst_pulse();
        req_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        req_par_en  = 4'b0101;
        req_par_typ = 4'b0011;
        req         = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_dv(lat);
            exp_id = i % 4;
            total++;
            if (lat !== ((i == 0) ? 1 : 2)) begin
                bad++;
                $display("FAIL rr_latency[%0d]: got %0d cycles, need %0d", i, lat, (i == 0) ? 1 : 2);
            end
            total++;
            if (gnt !== (4'b0001 << exp_id) || cur_id !== 2'(exp_id)) begin
                bad++;
                $display("FAIL rr_order[%0d]: gnt=%b id=%0d, need id %0d", i, gnt, cur_id, exp_id);
            end
            total++;
            if (p_data !== req_data[exp_id*8 +: 8] || par_en !== req_par_en[exp_id] ||
                par_typ !== req_par_typ[exp_id]) begin
                bad++;
                $display("FAIL rr_data[%0d]: pd=%h pe=%b pt=%b, need %h/%b/%b", i, p_data, par_en, par_typ,
                         req_data[exp_id*8 +: 8], req_par_en[exp_id], req_par_typ[exp_id]);
            end
            tick();
            busy = 1'b1;
            tick();
            tick();
            busy = 1'b0;
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_wrap;
        int lat;
        rst_pulse();
        req = 4'b1000;
        wait_dv(lat);
        total++;
        if (lat !== 1 || gnt !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_first: lat=%0d gnt=%b, need 1/1000", lat, gnt);
        end
        req = 4'b1001;
        finish_frame();
        wait_dv(lat);
        total++;
        if (lat !== 1 || gnt !== 4'b0001 || cur_id !== 2'd0) begin
            bad++;
            $display("FAIL wrap_to_0: lat=%0d gnt=%b id=%0d, need 1/0001/0", lat, gnt, cur_id);
        end
        finish_frame();
        wait_dv(lat);
        total++;
        if (lat !== 1 || gnt !== 4'b1000 || cur_id !== 2'd3) begin
            bad++;
            $display("FAIL wrap_to_3: lat=%0d gnt=%b id=%0d, need 1/1000/3", lat, gnt, cur_id);
        end
        req = 4'b0000;
        finish_frame();
    endtask

    task automatic test_timeout;
        int lat;
        int seen;
        req = 4'b0110;
        wait_dv(lat);
        total++;
        if (lat !== 1 || gnt !== 4'b0010) begin
            bad++;
            $display("FAIL tmo_grant: lat=%0d gnt=%b, need 1/0010", lat, gnt);
        end
        seen = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (tmo === 1'b1) begin
                seen = k;
                break;
            end
        end
        total++;
        if (seen !== 16) begin
            bad++;
            $display("FAIL tmo_delay: pulse after %0d cycles, need 16", seen);
        end
        tick();
        total++;
        if (tmo !== 1'b0 || active !== 1'b0 || dv !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pulse_end: tmo=%b act=%b dv=%b, need 0/0/0", tmo, active, dv);
        end
        wait_dv(lat);
        total++;
        if (lat !== 1 || gnt !== 4'b0100 || cur_id !== 2'd2) begin
            bad++;
            $display("FAIL tmo_next: lat=%0d gnt=%b id=%0d, need 1/0100/2", lat, gnt, cur_id);
        end
        req = 4'b0000;
        finish_frame();
    endtask

    task automatic test_ext_busy;
        busy = 1'b1;
        req  = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (gnt !== 4'b0 || dv !== 1'b0) begin
                bad++;
                $display("FAIL ext_busy_hold[%0d]: gnt=%b dv=%b, need 0000/0", k, gnt, dv);
            end
        end
        busy = 1'b0;
        tick();
        total++;
        if (gnt !== 4'b0001 || dv !== 1'b1) begin
            bad++;
            $display("FAIL ext_busy_release: gnt=%b dv=%b, need 0001/1", gnt, dv);
        end
        req = 4'b0000;
        finish_frame();
    endtask

    task automatic test_reset_mid;
        int lat;
        req = 4'b0100;
        wait_dv(lat);
        req = 4'b0000;
        tick();
        busy = 1'b1;
        tick();
        tick();
        total++;
        if (active !== 1'b1 || p_data !== 8'h33 || par_en !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup: act=%b pd=%h pe=%b, need 1/33/1", active, p_data, par_en);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({gnt, dv, active, tmo, par_en, par_typ} !== 10'b0 || p_data !== 8'h00 || cur_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_async_reset: gnt=%b dv=%b act=%b pe=%b pt=%b pd=%h id=%0d, need all 0",
                     gnt, dv, active, par_en, par_typ, p_data, cur_id);
        end
        #2;
        rst = 1'b0;
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (dv !== 1'b0 || gnt !== 4'b0) begin
                bad++;
                $display("FAIL mid_busy_gate[%0d]: dv=%b gnt=%b, need 0/0000", k, dv, gnt);
            end
        end
        busy = 1'b0;
        tick();
        total++;
        if (dv !== 1'b1 || gnt !== 4'b0001) begin
            bad++;
            $display("FAIL mid_after_busy: dv=%b gnt=%b, need 1/0001", dv, gnt);
        end
        req = 4'b0000;
        finish_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_ext_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
